// File: rtl/capture_ctrl.sv
// Capture sequencer for the circular sample buffer: arm/clear, pre-trigger fill,
// post-trigger count, then oldest-first readout over a valid/ready port.
module capture_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_len,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  buf_clear,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] trig_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRE,
    S_POST,
    S_READ
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0]   trig_idx_q, trig_idx_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   waddr_next;

  assign buf_clear    = (state_q == S_CLEAR);
  assign write_enable = (state_q == S_PRE) || (state_q == S_POST);
  assign rd_valid     = (state_q == S_READ);
  assign busy         = (state_q != S_IDLE);
  assign rd_last      = (state_q == S_READ) && (rd_cnt_q == '1);
  assign rd_addr      = waddr + rd_cnt_q;
  assign trig_index   = trig_idx_q;
  assign done         = done_q;

  // The final write advances waddr on the READ-entry edge, so the index is
  // taken against the post-increment address (the oldest sample).
  assign waddr_next = waddr + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    rd_cnt_d    = rd_cnt_q;
    trig_idx_d  = trig_idx_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d    = S_CLEAR;
            post_cnt_d = post_len;
          end
        end
        S_CLEAR: begin
          state_d = S_PRE;
        end
        S_PRE: begin
          if (primed && trigger) begin
            trig_addr_d = waddr;
            if (post_cnt_q == '0) begin
              state_d    = S_READ;
              rd_cnt_d   = '0;
              trig_idx_d = waddr - waddr_next;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
          if (post_cnt_q == ADDR_WIDTH'(1)) begin
            state_d    = S_READ;
            rd_cnt_d   = '0;
            trig_idx_d = trig_addr_q - waddr_next;
          end
        end
        S_READ: begin
          if (rd_ready) begin
            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
            if (rd_last) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      rd_cnt_q    <= '0;
      trig_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      trig_idx_q  <= trig_idx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural write_mem address/primed model.
module tb_capture_ctrl;

  logic       clk;
  logic       reset;
  logic       arm;
  logic       abort;
  logic       trigger;
  logic [3:0] post_len;
  logic [3:0] waddr;
  logic       primed;
  logic       buf_clear;
  logic       write_enable;
  logic [3:0] rd_addr;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_last;
  logic [3:0] trig_index;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int writes   = 0;
  int w0;

  capture_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .post_len     (post_len),
    .waddr        (waddr),
    .primed       (primed),
    .buf_clear    (buf_clear),
    .write_enable (write_enable),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .trig_index   (trig_index),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write_mem address counter and primed flag
  initial begin
    waddr  = 4'd0;
    primed = 1'b0;
  end
  always @(posedge clk) begin
    if (buf_clear) begin
      waddr  <= 4'd0;
      primed <= 1'b0;
    end else if (write_enable) begin
      waddr  <= waddr + 4'd1;
      writes <= writes + 1;
      if (waddr == 4'd15) primed <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_capture(input logic [3:0] len);
    arm      = 1'b1;
    post_len = len;
    tick();
    arm      = 1'b0;
    post_len = 4'hF;
    check("clear_state", {31'd0, buf_clear}, 32'd1);
    tick();
    check("pre_we", {31'd0, write_enable}, 32'd1);
    check("pre_waddr", {28'd0, waddr}, 32'd0);
    w0 = writes;
  endtask

  task automatic wait_read();
    int cyc = 0;
    while (!rd_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("read_reached", {31'd0, rd_valid}, 32'd1);
    check("read_we_off", {31'd0, write_enable}, 32'd0);
  endtask

  task automatic wait_primed();
    int cyc = 0;
    while (!primed && cyc < 100) begin
      tick();
      cyc++;
    end
    check("primed_reached", {31'd0, primed}, 32'd1);
  endtask

  task automatic drain(input int base, input bit rnd, input string tag);
    int xfers = 0;
    int dones = 0;
    int cyc   = 0;
    while (rd_valid && cyc < 300) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, "_addr"}, {28'd0, rd_addr}, 32'((base + xfers) % 16));
      check({tag, "_last"}, {31'd0, rd_last}, {31'd0, (xfers == 15)});
      if (rd_ready) xfers++;
      tick();
      cyc++;
      if (done) dones++;
    end
    rd_ready = 1'b0;
    check({tag, "_xfers"}, xfers, 16);
    check({tag, "_done_once"}, dones, 1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    if (!rnd) check({tag, "_cycles"}, cyc, 16);
    tick();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    arm      = 1'b0;
    abort    = 1'b0;
    trigger  = 1'b0;
    post_len = 4'd0;
    rd_ready = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_clear", {31'd0, buf_clear}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rdaddr", {28'd0, rd_addr}, {28'd0, waddr});
    check("rst_tidx", {28'd0, trig_index}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // early trigger, post_len 5
    trigger = 1'b1;
    start_capture(4'd5);
    wait_read();
    trigger = 1'b0;
    check("early_writes", writes - w0, 22);
    check("early_waddr", {28'd0, waddr}, 32'd6);
    check("early_tidx", {28'd0, trig_index}, 32'd10);
    drain(6, 1'b0, "early");

    // zero post length, trigger at waddr 9, then backpressured readout
    start_capture(4'd0);
    begin
      int cyc = 0;
      while (!(primed && waddr == 4'd9) && cyc < 100) begin
        tick();
        cyc++;
      end
    end
    check("zero_at9", {28'd0, waddr}, 32'd9);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("zero_read", {31'd0, rd_valid}, 32'd1);
    check("zero_waddr", {28'd0, waddr}, 32'd10);
    check("zero_tidx", {28'd0, trig_index}, 32'd15);
    check("zero_writes", writes - w0, 26);
    drain(10, 1'b1, "bp");

    // abort after 4 transfers
    trigger = 1'b1;
    start_capture(4'd2);
    wait_read();
    trigger = 1'b0;
    check("abort_waddr", {28'd0, waddr}, 32'd3);
    check("abort_tidx0", {28'd0, trig_index}, 32'd13);
    rd_ready = 1'b1;
    repeat (4) tick();
    check("abort_addr4", {28'd0, rd_addr}, 32'd7);
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    rd_ready = 1'b0;
    check("abort_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_tidx", {28'd0, trig_index}, 32'd13);
    tick();
    check("abort_done2", {31'd0, done}, 32'd0);

    // reset asserted mid-POST
    trigger = 1'b1;
    start_capture(4'd5);
    wait_primed();
    tick();
    check("post_we", {31'd0, write_enable}, 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_we", {31'd0, write_enable}, 32'd0);
    check("mrst_valid", {31'd0, rd_valid}, 32'd0);
    check("mrst_last", {31'd0, rd_last}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_rdaddr", {28'd0, rd_addr}, {28'd0, waddr});
    check("mrst_tidx", {28'd0, trig_index}, 32'd0);
    w0 = writes;
    tick();
    check("mrst_nowrite", writes - w0, 0);
    reset = 1'b1;
    tick();
    check("mrst_stay_idle", {31'd0, busy}, 32'd0);

    // arm pulsed during POST is ignored
    start_capture(4'd3);
    wait_primed();
    tick();
    arm      = 1'b1;
    post_len = 4'd9;
    tick();
    arm = 1'b0;
    check("armpost_clear", {31'd0, buf_clear}, 32'd0);
    wait_read();
    trigger = 1'b0;
    check("armpost_writes", writes - w0, 20);
    check("armpost_waddr", {28'd0, waddr}, 32'd4);
    check("armpost_tidx", {28'd0, trig_index}, 32'd12);
    drain(4, 1'b0, "armpost");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencer for the logic analyzer's circular capture buffer (`write_mem`). It arms the buffer and clears it for a fresh fill. It waits until the buffer is primed, accepts a trigger, and records a programmable number of post-trigger samples. It then streams the whole buffer out oldest-first over a valid/ready port. It sits between the trigger comparator and host readout logic, and drives `write_mem`'s `reset` and `write_enable`.

## Interface
- `ADDR_WIDTH`, default 4: buffer address width; the buffer holds 2^ADDR_WIDTH samples. Must match `write_mem`.
- `clk` input, 1 bit: sole clock; all logic on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `arm` input, 1 bit: start a capture; honoured only in IDLE.
- `abort` input, 1 bit: cancel any capture or readout; highest priority after `reset`.
- `trigger` input, 1 bit: trigger condition, sampled every cycle.
- `post_len` input, ADDR_WIDTH bits: samples to record after the trigger sample; latched on arm.
- `waddr` input, ADDR_WIDTH bits: `write_mem` write address.
- `primed` input, 1 bit: `write_mem` all-locations-written flag.
- `buf_clear` output, 1 bit: drives `write_mem` `reset` (active-high, synchronous).
- `write_enable` output, 1 bit: drives `write_mem` `write_enable`.
- `rd_addr` output, ADDR_WIDTH bits: buffer address for the external readout mux.
- `rd_valid` output, 1 bit: the readout sample at `rd_addr` is offered.
- `rd_ready` input, 1 bit: consumer accepts the readout sample.
- `rd_last` output, 1 bit: the offered sample is the final one.
- `trig_index` output, ADDR_WIDTH bits: position of the trigger sample in the readout stream.
- `busy` output, 1 bit: the state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when a readout completes.

## Operation
- **States:** IDLE, CLEAR, PRE, POST, READ. Output decode:
  - `buf_clear` = (CLEAR).
  - `write_enable` = (PRE | POST).
  - `rd_valid` = (READ).
  - `busy` = (state != IDLE).
- **IDLE:** `arm`=1 → CLEAR, and latch `post_len` into `post_cnt`. `arm` in any other state is ignored.
- **CLEAR:** lasts exactly one cycle, then → PRE. `write_mem` sees its reset on this edge: `waddr`=0, `primed`=0.
- **PRE:** samples are written every cycle. `trigger` is ignored while `primed`=0.
- **Trigger accept:** in PRE with `primed`=1 and `trigger`=1:
  - the sample written that cycle is the trigger sample; latch `trig_addr` <= `waddr`;
  - if `post_cnt`=0 → READ, else → POST.
- **POST:** one sample written per cycle. `post_cnt` decrements each cycle; when `post_cnt`=1 → READ. Exactly `post_len` samples follow the trigger sample.
- **READ, addressing:**
  - `waddr` is static because `write_enable`=0; it points at the oldest sample.
  - `rd_cnt` (ADDR_WIDTH bits) is cleared on READ entry.
  - `rd_addr` = `waddr` + `rd_cnt`, mod 2^ADDR_WIDTH.
- **READ, transfer:** occurs when `rd_valid` & `rd_ready`; each transfer increments `rd_cnt`.
- **READ, completion:**
  - `rd_last` = READ & (`rd_cnt` all-ones).
  - The transfer with `rd_last`=1 → IDLE and sets `done` for the next cycle only.
- **Trigger position:** `trig_index` = `trig_addr` − `waddr`, mod 2^ADDR_WIDTH. Registered on READ entry; holds until the next arm.
- **Abort:** `abort`=1 in any state → IDLE on the next edge. No `done`, no further writes; `trig_index` is unchanged.
- **Simultaneous events:** `abort` beats `arm`, `trigger` and the final transfer.

## Timing
- **Reset values:** while `reset`=0, outputs are forced asynchronously to the following, with no clock needed:
  - state IDLE;
  - `buf_clear`, `write_enable`, `rd_valid`, `rd_last`, `busy`, `done` = 0;
  - `rd_addr` = `waddr`;
  - `trig_index` = 0, `post_cnt` = 0, `rd_cnt` = 0.
- **Reset mid-capture:** all activity is lost; a new `arm` is required after release.
- **Arm to first write:** `arm` sampled at edge N → CLEAR during cycle N+1 → first write (`waddr`=0) during cycle N+2.
- **Earliest trigger:** `primed` rises after 2^ADDR_WIDTH writes, so the earliest trigger sample is the (2^ADDR_WIDTH+1)-th write.
- **Write stop:** `write_enable` falls in the cycle after the last POST write (or after the trigger write when `post_len`=0). No partial or extra writes.
- **Readout stall:** `rd_addr` and `rd_last` are stable while `rd_valid`=1 and `rd_ready`=0. One transfer per cycle at most; 2^ADDR_WIDTH cycles minimum at full throughput.
- **`trigger` and `post_len` changes:** changes outside the sampling points have no effect.

## Test plan
1. **Reset mid-POST:** assert `reset`=0 during POST → all outputs read the reset values before the next clock edge. Release and `arm` → a normal capture follows.
2. **Early trigger:** ADDR_WIDTH=4, `post_len`=5, `trigger` held 1 from arm.
   - No trigger accepted for the first 16 writes; the 17th write (`waddr`=0) is the trigger sample.
   - 5 more writes; READ with `waddr`=6 and `trig_index`=10.
   - `rd_addr` runs 6..15,0..5, `rd_last` on the 16th transfer, then `done` pulses for 1 cycle.
3. **Zero post-trigger length:** `post_len`=0, trigger pulse when `waddr`=9 in PRE → READ next cycle with `waddr`=10, `trig_index`=15, exactly 17+k writes total.
4. **Backpressure:** `rd_ready` toggled pseudo-randomly in READ → exactly 16 transfers in address order. `rd_addr` holds during stalls; `done` comes exactly once.
5. **Abort during READ:** assert `abort` after 4 transfers → IDLE next cycle, `rd_valid`=0, no `done`.
6. **Arm while busy:** `arm` pulsed in POST → ignored; the capture completes unchanged.
